// File: rtl/serial_addsub.sv
// serial_addsub: bit-serial adder/subtractor, LSB first, one bit per clock.
// A WIDTH-bit operand pair is captured on a start/ready handshake and processed
// over WIDTH cycles. Each result bit is streamed on z_o. The completed word,
// carry and signed overflow are presented together with a one-cycle done_o.
//
// Ports:
//   clk_i      system clock, rising edge
//   rst_ni     asynchronous active-low reset
//   start_i    request a new operation (honoured only while ready_o=1)
//   op_i       0 = a+b, 1 = a-b (captured with start_i)
//   a_i, b_i   operands (captured with start_i)
//   ready_o    block idle
//   z_o        serial result bit (holds its last value when z_valid_o=0)
//   z_valid_o  z_o carries a valid result bit
//   sum_o      parallel result of the last completed operation
//   cout_o     add: carry out of the MSB; sub: 1 = no borrow
//   ovf_o      two's-complement overflow of the last completed operation
//   done_o     one-cycle pulse when sum_o/cout_o/ovf_o update
module serial_addsub #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             z_o,
  output logic             z_valid_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             done_o
);

  localparam int unsigned CntW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_sh_q, a_sh_d;
  logic [WIDTH-1:0]  b_sh_q, b_sh_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              op_q, op_d;
  logic              carry_q, carry_d;
  logic              z_q, z_d;
  logic              z_valid_q, z_valid_d;
  logic [WIDTH-1:0]  sum_q, sum_d;
  logic              cout_q, cout_d;
  logic              ovf_q, ovf_d;
  logic              done_q, done_d;

  // Full-adder slice; subtraction is a + ~b + 1 with the +1 preloaded into carry.
  logic a_bit, b_bit, bit_s, carry_nxt, last_bit;

  always_comb begin
    a_bit     = a_sh_q[0];
    b_bit     = b_sh_q[0] ^ op_q;
    bit_s     = a_bit ^ b_bit ^ carry_q;
    carry_nxt = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);
    last_bit  = (cnt_q == CntW'(WIDTH - 1));
  end

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    carry_d   = carry_q;
    z_d       = z_q;
    z_valid_d = z_valid_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_i) begin
          a_sh_d  = a_i;
          b_sh_d  = b_i;
          op_d    = op_i;
          carry_d = op_i;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        z_d              = bit_s;
        z_valid_d        = 1'b1;
        res_d            = res_q >> 1;
        res_d[WIDTH-1]   = bit_s;
        a_sh_d           = a_sh_q >> 1;
        b_sh_d           = b_sh_q >> 1;
        carry_d          = carry_nxt;
        cnt_d            = cnt_q + CntW'(1);
        if (last_bit) begin
          sum_d   = res_d;
          cout_d  = carry_nxt;
          // carry_q here is the carry into the MSB.
          ovf_d   = carry_q ^ carry_nxt;
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        z_valid_d = 1'b0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      carry_q   <= 1'b0;
      z_q       <= 1'b0;
      z_valid_q <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      carry_q   <= carry_d;
      z_q       <= z_d;
      z_valid_q <= z_valid_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign ready_o   = (state_q == StIdle);
  assign z_o       = z_q;
  assign z_valid_o = z_valid_q;
  assign sum_o     = sum_q;
  assign cout_o    = cout_q;
  assign ovf_o     = ovf_q;
  assign done_o    = done_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: two instances (WIDTH=8 and WIDTH=4) checked every
// cycle against an arithmetic reference model, plus directed literal checks.
module tb_serial_addsub;

  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  // Index 0 drives the 8-bit instance, index 1 the 4-bit instance.
  logic        start_s [2];
  logic        op_s    [2];
  logic [31:0] a_s     [2];
  logic [31:0] b_s     [2];

  logic       ready8, z8, zv8, cout8, ovf8, done8;
  logic [7:0] sum8;
  logic       ready4, z4, zv4, cout4, ovf4, done4;
  logic [3:0] sum4;

  serial_addsub #(.WIDTH(8)) dut8 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_s[0]),
    .op_i     (op_s[0]),
    .a_i      (a_s[0][7:0]),
    .b_i      (b_s[0][7:0]),
    .ready_o  (ready8),
    .z_o      (z8),
    .z_valid_o(zv8),
    .sum_o    (sum8),
    .cout_o   (cout8),
    .ovf_o    (ovf8),
    .done_o   (done8)
  );

  serial_addsub #(.WIDTH(4)) dut4 (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (start_s[1]),
    .op_i     (op_s[1]),
    .a_i      (a_s[1][3:0]),
    .b_i      (b_s[1][3:0]),
    .ready_o  (ready4),
    .z_o      (z4),
    .z_valid_o(zv4),
    .sum_o    (sum4),
    .cout_o   (cout4),
    .ovf_o    (ovf4),
    .done_o   (done4)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  int unsigned wid [2] = '{8, 4};
  int          m_phase [2];   // 0 idle, 1..w bit edges, w+1 done edge
  logic [31:0] m_pr  [2];
  logic        m_pc  [2];
  logic        m_pv  [2];
  logic        m_z   [2];
  logic        m_zv  [2];
  logic [31:0] m_sum [2];
  logic        m_cout[2];
  logic        m_ovf [2];
  logic        m_done[2];

  function automatic void compute(input int unsigned w, input logic op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] r,
                                  output logic c, output logic v);
    logic [63:0] mask, ua, ub, full;
    mask = (64'd1 << w) - 64'd1;
    ua   = {32'd0, a} & mask;
    ub   = {32'd0, b} & mask;
    if (op) begin
      full = ua - ub;
      c    = (ua >= ub);
    end else begin
      full = ua + ub;
      c    = full[w];
    end
    r = full[31:0] & mask[31:0];
    if (op) v = (ua[w-1] != ub[w-1]) && (r[w-1] != ua[w-1]);
    else    v = (ua[w-1] == ub[w-1]) && (r[w-1] != ua[w-1]);
  endfunction

  task automatic model_reset(input int d);
    m_phase[d] = 0;
    m_z[d] = 0; m_zv[d] = 0; m_sum[d] = 0; m_cout[d] = 0; m_ovf[d] = 0; m_done[d] = 0;
  endtask

  task automatic model_step(input int d);
    int w;
    w = int'(wid[d]);
    if (m_phase[d] == 0) begin
      if (start_s[d]) begin
        compute(wid[d], op_s[d], a_s[d], b_s[d], m_pr[d], m_pc[d], m_pv[d]);
        m_phase[d] = 1;
      end
    end else if (m_phase[d] <= w) begin
      m_zv[d] = 1'b1;
      m_z[d]  = m_pr[d][m_phase[d]-1];
      if (m_phase[d] == w) begin
        m_done[d] = 1'b1;
        m_sum[d]  = m_pr[d];
        m_cout[d] = m_pc[d];
        m_ovf[d]  = m_pv[d];
      end
      m_phase[d]++;
    end else begin
      m_zv[d]    = 1'b0;
      m_done[d]  = 1'b0;
      m_phase[d] = 0;
    end
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk_i or negedge rst_ni);
      if (!rst_ni) begin
        model_reset(0);
        model_reset(1);
      end else begin
        model_step(0);
        model_step(1);
      end
    end
  end

  // ---------------- Per-cycle compare ----------------
  task automatic cmp_dut(input string p, input int d, input logic rdy, input logic z,
                         input logic zv, input logic [31:0] sum, input logic c,
                         input logic v, input logic dn);
    check({p, ".ready"}, rdy, m_phase[d] == 0);
    check({p, ".z"}, z, m_z[d]);
    check({p, ".z_valid"}, zv, m_zv[d]);
    check({p, ".sum"}, sum, m_sum[d]);
    check({p, ".cout"}, c, m_cout[d]);
    check({p, ".ovf"}, v, m_ovf[d]);
    check({p, ".done"}, dn, m_done[d]);
  endtask

  always @(negedge clk_i) begin
    cmp_dut("w8", 0, ready8, z8, zv8, {24'd0, sum8}, cout8, ovf8, done8);
    cmp_dut("w4", 1, ready4, z4, zv4, {28'd0, sum4}, cout4, ovf4, done4);
  end

  // ---------------- Directed stimulus ----------------
  // Called at a negedge with dut8 idle; returns at a negedge with dut8 idle again.
  task automatic run_op8(input logic op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] esum, input logic ecout, input logic eovf);
    a_s[0] = {24'd0, a}; b_s[0] = {24'd0, b}; op_s[0] = op; start_s[0] = 1'b1;
    @(negedge clk_i);
    start_s[0] = 1'b0;
    check("lit.ready_low", ready8, 1'b0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk_i);
      check("lit.z_valid", zv8, 1'b1);
      check("lit.z_bit", z8, esum[k]);
    end
    check("lit.done", done8, 1'b1);
    check("lit.sum", sum8, esum);
    check("lit.cout", cout8, ecout);
    check("lit.ovf", ovf8, eovf);
    @(negedge clk_i);
    check("lit.ready_back", ready8, 1'b1);
    check("lit.done_cleared", done8, 1'b0);
  endtask

  initial begin
    int prev_i, ndone, nzv;
    int d4 [2];
    rst_ni = 1'b0;
    for (int d = 0; d < 2; d++) begin
      start_s[d] = 0; op_s[d] = 0; a_s[d] = 0; b_s[d] = 0;
    end
    repeat (2) @(negedge clk_i);
    check("reset.ready", ready8, 1'b1);
    check("reset.sum", sum8, 8'h00);
    rst_ni = 1'b1;

    // First start accepted on the first edge after release.
    run_op8(1'b0, 8'h5A, 8'h3C, 8'h96, 1'b0, 1'b1);
    run_op8(1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op8(1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op8(1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0);
    run_op8(1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1);

    // Asynchronous reset in the middle of an add.
    a_s[0] = 32'h5A; b_s[0] = 32'h3C; op_s[0] = 1'b0; start_s[0] = 1'b1;
    @(negedge clk_i);
    start_s[0] = 1'b0;
    repeat (4) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("arst.ready", ready8, 1'b1);
    check("arst.z", z8, 1'b0);
    check("arst.z_valid", zv8, 1'b0);
    check("arst.sum", sum8, 8'h00);
    check("arst.cout", cout8, 1'b0);
    check("arst.ovf", ovf8, 1'b0);
    check("arst.done", done8, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    run_op8(1'b0, 8'h01, 8'h01, 8'h02, 1'b0, 1'b0);

    // Start held high with fresh random operands every cycle.
    start_s[0] = 1'b1;
    a_s[0] = {24'd0, 8'($urandom)}; b_s[0] = {24'd0, 8'($urandom)}; op_s[0] = 1'($urandom);
    prev_i = -1;
    ndone  = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (done8) begin
        ndone++;
        if (prev_i >= 0) check("hs.interval", i - prev_i, 10);
        prev_i = i;
      end
      a_s[0] = {24'd0, 8'($urandom)}; b_s[0] = {24'd0, 8'($urandom)}; op_s[0] = 1'($urandom);
    end
    start_s[0] = 1'b0;
    check("hs.done_count", ndone, 5);
    @(negedge clk_i);

    // WIDTH=4: 0x7+0x1, start held so the second accept lands 6 cycles later.
    a_s[1] = 32'h7; b_s[1] = 32'h1; op_s[1] = 1'b0; start_s[1] = 1'b1;
    ndone = 0; nzv = 0; d4[0] = -1; d4[1] = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (i >= 1 && i <= 4) check("w4lit.z_bit", z4, (i == 4));
      if (i <= 5 && zv4) nzv++;
      if (done4) begin
        if (ndone < 2) d4[ndone] = i;
        ndone++;
        check("w4lit.sum", sum4, 4'h8);
        check("w4lit.ovf", ovf4, 1'b1);
        check("w4lit.cout", cout4, 1'b0);
      end
    end
    start_s[1] = 1'b0;
    check("w4lit.zv_cycles", nzv, 4);
    check("w4lit.done_count", ndone, 2);
    check("w4lit.first_done", d4[0], 4);
    check("w4lit.second_done", d4[1], 10);
    repeat (2) @(negedge clk_i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Parametrised bit-serial adder/subtractor. It is the word-level successor to the single-bit serial adder. A WIDTH-bit operand pair is accepted with a start/ready handshake and processed LSB-first, one bit per clock. Each result bit is streamed out serially, and the completed word is presented in parallel with carry and signed-overflow flags. The block sits between parallel register logic and bit-serial datapaths that need both the bit stream and the final word.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new operation; sampled only while ready=1.
- op  in  1  0 = add (a+b), 1 = subtract (a−b); captured with start.
- a  in  WIDTH  operand A; captured with start.
- b  in  WIDTH  operand B; captured with start.
- ready  out  1  block idle, start will be accepted.
- z  out  1  serial result bit, LSB first.
- z_valid  out  1  z carries a valid result bit this cycle.
- sum  out  WIDTH  parallel result of the last completed operation.
- cout  out  1  add: carry out of MSB. Sub: 1 = no borrow (a ≥ b unsigned).
- ovf  out  1  signed (two's-complement) overflow of the last completed operation.
- done  out  1  one-cycle pulse; sum/cout/ovf are updated this cycle.

## Operation
- FSM states:
  - IDLE: ready=1.
  - RUN: WIDTH bit cycles.
  - DONE: one cycle, then back to IDLE.
- Start acceptance: at an edge with start=1 in IDLE, the block captures a, b and op into shift registers. It sets carry=op, clears the bit counter and moves to RUN.
- Starts seen outside IDLE are ignored, not queued.
- Per RUN edge:
  - bit = a_sh[0] ^ (b_sh[0] ^ op) ^ carry
  - carry' = majority(a_sh[0], b_sh[0]^op, carry)
  - z ← bit, z_valid ← 1
  - The result shift register takes bit in at its MSB and shifts right.
  - Operand registers shift right. Counter increments.
- Final RUN edge (counter = WIDTH−1):
  - sum ← completed word.
  - cout ← carry'.
  - ovf ← carry into MSB XOR carry'.
  - done ← 1. State → DONE.
- DONE edge: done ← 0, z_valid ← 0, state → IDLE.
- Operand/op changes after capture have no effect on the operation in flight.
- sum, cout and ovf change only at the completion edge and hold until the next completion. No partial results are ever visible.
- z holds its last value when z_valid=0.
- Reset (rst low, async):
  - State → IDLE; ready=1.
  - z, z_valid, sum, cout, ovf, done = 0.
  - Any operation in flight is aborted and produces no done.
- Arithmetic wraps modulo 2^WIDTH.

## Timing
- Accept edge E0. Bit k (k = 0..WIDTH−1) appears on z after edge E(k+1); z_valid is high for exactly WIDTH consecutive cycles.
- done, sum, cout and ovf are valid in the cycle after E_WIDTH, coincident with the last z bit.
- ready falls after E0 and returns after E(WIDTH+1).
- The earliest next accept is E(WIDTH+2), so throughput is one operation per WIDTH+2 cycles.
- Reset release: the first start can be accepted on the first rising edge with rst high.

## Test plan
- Reset:
  - Drive rst low mid-RUN, at bit 4 of an 8-bit add.
  - Required: all outputs 0 and ready=1 immediately, with no done pulse.
  - After release, a fresh 0x01+0x01 gives sum=0x02.
- Add, WIDTH=8, a=0x5A, b=0x3C, op=0:
  - z stream 0,1,1,0,1,0,0,1 on 8 consecutive z_valid cycles.
  - done with sum=0x96, cout=0, ovf=1.
- Add with wrap, WIDTH=8, 0xFF+0x01: sum=0x00, cout=1, ovf=0. Back-to-back 0x7F+0x01: sum=0x80, ovf=1.
- Subtract, WIDTH=8:
  - 0x10−0x20: sum=0xF0, cout=0, ovf=0.
  - 0x80−0x01: sum=0x7F, cout=1, ovf=1.
- Handshake:
  - Hold start=1 and randomise a/b every cycle.
  - Operations are accepted exactly every 10 cycles (WIDTH=8).
  - Each result matches the operands present at its accept edge.
  - done pulses once per operation.
- Parameter, WIDTH=4: 0x7+0x1 gives sum=0x8, ovf=1, cout=0. z_valid is high for 4 cycles; the next accept is 6 cycles after the first.
